// File: rtl/pc_pkg.sv
// Shared types and defaults for the PC / instruction-fetch slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,  // fetch request outstanding at PC
    FULL = 2'd1,  // instruction held for decode
    DROP = 2'd2   // in-flight word will be discarded, then fetch pending target
  } fetch_state_t;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory req/ack port: req + addr out from fetch, ack + rdata back.
// Latency: memory may ack any number of cycles after req (minimum one).
// Backpressure: the requester holds req/addr stable until ack.
interface pc_fetch_unit_if;
  import pc_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_register.sv
// Program-counter flop: loads the word-aligned D input when en is high.
// Latency: one cycle from en to q.
// Backpressure: none; holds value while en is low.
// Ports: clk, rst_n (sync, active-low -> RESET_PC), en, d (any alignment), q.
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (en) begin
      // Instructions are word aligned; the low two bits are always dropped.
      q <= d & ~32'h0000_0003;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register + fetch sequencer: requests imem at PC, holds one instruction for decode.
// Latency: instruction visible the cycle after imem_ack; new request the cycle after PC load.
// Backpressure: decode stalls by withholding pc_write/redirect; FULL holds instr indefinitely.
// Ports: clk, rst_n (sync, active-low), nextPC/pc_write/redirect from control, imem master port,
//        instr/instr_valid to decode, PC/pc_increment to the PC-source mux, addr_misaligned, busy.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        nextPC,
  input  logic               pc_write,
  input  logic               redirect,
  pc_fetch_unit_if.master    imem,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [31:0]        PC,
  output logic [31:0]        pc_increment,
  output logic               addr_misaligned,
  output logic               busy
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pending_q;
  logic         pc_en;
  logic [31:0]  pc_d;
  logic         pend_en;
  logic         capture;
  logic         clear_valid;
  logic         take_target;

  pc_register #(.RESET_PC(RESET_PC)) u_pc_register (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pc_en),
    .d     (pc_d),
    .q     (PC)
  );

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    pc_d        = nextPC;
    pend_en     = 1'b0;
    capture     = 1'b0;
    clear_valid = 1'b0;
    take_target = 1'b0;
    case (state_q)
      REQ: begin
        if (redirect) begin
          take_target = 1'b1;
          if (imem.imem_ack) begin
            // Word arrives together with the redirect: drop it, fetch the target next.
            pc_en = 1'b1;
          end else begin
            // Word still in flight: park the target until the stale ack drains.
            pend_en = 1'b1;
            state_d = DROP;
          end
        end else if (imem.imem_ack) begin
          capture = 1'b1;
          state_d = FULL;
        end
      end
      DROP: begin
        if (redirect) begin
          take_target = 1'b1;
          pend_en     = 1'b1;
          if (imem.imem_ack) begin
            // Latest redirect wins over the parked target.
            pc_en   = 1'b1;
            state_d = REQ;
          end
        end else if (imem.imem_ack) begin
          pc_en   = 1'b1;
          pc_d    = pending_q;
          state_d = REQ;
        end
      end
      FULL: begin
        if (pc_write || redirect) begin
          take_target = 1'b1;
          pc_en       = 1'b1;
          clear_valid = 1'b1;
          state_d     = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= REQ;
      pending_q       <= 32'h0000_0000;
      instr           <= '0;
      instr_valid     <= 1'b0;
      addr_misaligned <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pend_en) begin
        pending_q <= {nextPC[31:2], 2'b00};
      end
      if (capture) begin
        instr       <= imem.imem_rdata;
        instr_valid <= 1'b1;
      end else if (clear_valid) begin
        instr_valid <= 1'b0;
      end
      addr_misaligned <= take_target && (nextPC[1:0] != 2'b00);
    end
  end

  // PC does not move in DROP, so PC is also the address of the word being drained.
  assign imem.imem_req  = (state_q == REQ) || (state_q == DROP);
  assign imem.imem_addr = PC;
  assign pc_increment   = PC + PC_STEP;
  assign busy           = (state_q != FULL);

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] nextPC;
  logic        pc_write;
  logic        redirect;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] pc_increment;
  logic        addr_misaligned;
  logic        busy;

  int total  = 0;
  int passed = 0;

  pc_fetch_unit_if imem ();

  pc_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .nextPC          (nextPC),
    .pc_write        (pc_write),
    .redirect        (redirect),
    .imem            (imem),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .PC              (PC),
    .pc_increment    (pc_increment),
    .addr_misaligned (addr_misaligned),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; nextPC = '0; pc_write = 1'b0; redirect = 1'b0;
    imem.imem_ack = 1'b0; imem.imem_rdata = '0;
    @(negedge clk);
    step();
    check("rst_pc", PC, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_mis", {31'b0, addr_misaligned}, 32'h0);
    check("rst_req", {31'b0, imem.imem_req}, 32'h1);
    rst_n = 1'b1;

    // 1: first fetch acked in cycle 1
    check("t1_addr", imem.imem_addr, 32'h0);
    check("t1_inc", pc_increment, 32'h4);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h2008_0005;
    step();
    imem.imem_ack = 1'b0;
    check("t1_instr", instr, 32'h2008_0005);
    check("t1_valid", {31'b0, instr_valid}, 32'h1);
    check("t1_req", {31'b0, imem.imem_req}, 32'h0);
    check("t1_busy", {31'b0, busy}, 32'h0);

    // 2: retire, then memory stalls 5 cycles
    pc_write = 1'b1; nextPC = 32'h4;
    step();
    pc_write = 1'b0;
    check("t2_pc", PC, 32'h4);
    check("t2_valid", {31'b0, instr_valid}, 32'h0);
    check("t2_req", {31'b0, imem.imem_req}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("t2_addr_hold", imem.imem_addr, 32'h4);
      check("t2_busy", {31'b0, busy}, 32'h1);
      step();
    end
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hAAAA_0001;
    step();
    imem.imem_ack = 1'b0;
    check("t2_instr", instr, 32'hAAAA_0001);
    step(); step();
    check("t2_stall_valid", {31'b0, instr_valid}, 32'h1);
    check("t2_stall_req", {31'b0, imem.imem_req}, 32'h0);

    // 3: redirect while request outstanding, stale ack 3 cycles later
    pc_write = 1'b1; nextPC = 32'h8;
    step();
    pc_write = 1'b0;
    check("t3_pc", PC, 32'h8);
    redirect = 1'b1; nextPC = 32'h40;
    step();
    redirect = 1'b0;
    check("t3_drop_addr", imem.imem_addr, 32'h8);
    check("t3_drop_req", {31'b0, imem.imem_req}, 32'h1);
    step(); step();
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
    step();
    imem.imem_ack = 1'b0;
    check("t3_addr", imem.imem_addr, 32'h40);
    check("t3_valid", {31'b0, instr_valid}, 32'h0);
    check("t3_instr", instr, 32'hAAAA_0001);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h1111_1111;
    step();
    imem.imem_ack = 1'b0;
    check("t3_fetch", instr, 32'h1111_1111);

    // 4: two redirects, last one wins
    pc_write = 1'b1; nextPC = 32'h20;
    step();
    pc_write = 1'b0;
    redirect = 1'b1; nextPC = 32'h80;
    step();
    nextPC = 32'h100;
    step();
    redirect = 1'b0;
    check("t4_drop_addr", imem.imem_addr, 32'h20);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hBAD0_0004;
    step();
    imem.imem_ack = 1'b0;
    check("t4_addr", imem.imem_addr, 32'h100);
    check("t4_valid", {31'b0, instr_valid}, 32'h0);

    // redirect coincident with ack in REQ: word dropped, target fetched next
    redirect = 1'b1; nextPC = 32'h30; imem.imem_ack = 1'b1;
    step();
    redirect = 1'b0; imem.imem_ack = 1'b0;
    check("t4b_addr", imem.imem_addr, 32'h30);
    check("t4b_valid", {31'b0, instr_valid}, 32'h0);
    check("t4b_req", {31'b0, imem.imem_req}, 32'h1);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h3333_3333;
    step();
    imem.imem_ack = 1'b0;

    // 5: wraparound and misaligned target
    pc_write = 1'b1; nextPC = 32'hFFFF_FFFC;
    step();
    pc_write = 1'b0;
    check("t5_pc", PC, 32'hFFFF_FFFC);
    check("t5_inc_wrap", pc_increment, 32'h0);
    check("t5_mis_lo", {31'b0, addr_misaligned}, 32'h0);
    imem.imem_ack = 1'b1;
    step();
    imem.imem_ack = 1'b0;
    pc_write = 1'b1; nextPC = 32'h0000_0013;
    step();
    pc_write = 1'b0;
    check("t5_pc_align", PC, 32'h10);
    check("t5_mis_pulse", {31'b0, addr_misaligned}, 32'h1);
    step();
    check("t5_mis_clear", {31'b0, addr_misaligned}, 32'h0);

    // 6: reset during DROP with ack present
    redirect = 1'b1; nextPC = 32'h200;
    step();
    redirect = 1'b0;
    check("t6_drop_addr", imem.imem_addr, 32'h10);
    rst_n = 1'b0; imem.imem_ack = 1'b1; imem.imem_rdata = 32'hBADB_AD00;
    step();
    rst_n = 1'b1; imem.imem_ack = 1'b0;
    check("t6_pc", PC, 32'h0);
    check("t6_valid", {31'b0, instr_valid}, 32'h0);
    check("t6_busy", {31'b0, busy}, 32'h1);
    check("t6_addr", imem.imem_addr, 32'h0);
    step();
    check("t6_no_capture", {31'b0, instr_valid}, 32'h0);
    check("t6_instr", instr, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
